// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one-cold row drive, synchronized column sampling,
// debounced press/release detection and a one-cycle valid pulse per accepted key.
module keypad_scan #(
    parameter int SCAN_DIV       = 16384,
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_pressed
);

    localparam int PS_W = $clog2(SCAN_DIV);
    localparam int DB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;

    logic [3:0]      col_m;
    logic [3:0]      col_s;
    logic [PS_W-1:0] ps_cnt;
    logic            tick;
    logic [1:0]      state;
    logic [1:0]      row_idx;
    logic [1:0]      row_next;
    logic [3:0]      row_adv;
    logic [1:0]      lat_col;
    logic [1:0]      first_col;
    logic            lat_low;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] rel_cnt;

    // Column lines are asynchronous to clk; idle (pulled-up) level is all ones.
    always_ff @(posedge clk) begin
        // NOTE: every sequential register uses non-blocking assignment so all
        // flops update from pre-edge values, independent of statement order.
        if (!rst_n) begin
            col_m <= 4'b1111;
            col_s <= 4'b1111;
        end else begin
            col_m <= col_n;
            col_s <= col_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (ps_cnt == PS_LAST) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    assign tick     = (ps_cnt == PS_LAST);
    assign row_next = row_idx + 2'd1;
    assign row_adv  = ~(4'b0001 << row_next);
    assign lat_low  = ~col_s[lat_col];

    always_comb begin
        // NOTE: default first so every path assigns first_col and no latch forms.
        first_col = 2'd0;
        if (!col_s[0])      first_col = 2'd0;
        else if (!col_s[1]) first_col = 2'd1;
        else if (!col_s[2]) first_col = 2'd2;
        else if (!col_s[3]) first_col = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_SCAN;
            row_idx     <= 2'd0;
            row_n       <= 4'b1110;
            lat_col     <= 2'd0;
            db_cnt      <= '0;
            rel_cnt     <= '0;
            key_valid   <= 1'b0;
            key_code    <= 4'd0;
            key_pressed <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (col_s == 4'b1111) begin
                            row_idx <= row_next;
                            row_n   <= row_adv;
                        end else begin
                            lat_col <= first_col;
                            db_cnt  <= '0;
                            state   <= ST_DEBOUNCE;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (lat_low) begin
                            if (db_cnt == DB_LAST) begin
                                key_code    <= {row_idx, lat_col};
                                key_valid   <= 1'b1;
                                key_pressed <= 1'b1;
                                rel_cnt     <= '0;
                                state       <= ST_HOLD;
                            end else begin
                                db_cnt <= db_cnt + 1'b1;
                            end
                        end else begin
                            // Bounce: abandon this key and move on to the next row.
                            row_idx <= row_next;
                            row_n   <= row_adv;
                            state   <= ST_SCAN;
                        end
                    end
                    ST_HOLD: begin
                        if (!lat_low) begin
                            if (rel_cnt == DB_LAST) begin
                                key_pressed <= 1'b0;
                                row_idx     <= row_next;
                                row_n       <= row_adv;
                                state       <= ST_SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + 1'b1;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                    default: state <= ST_SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical keypad model drives col_n from row_n, and a
// key-level reference model predicts every output on every cycle.
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_pressed;
    logic [15:0] keys = 16'h0000;

    int n_pass = 0;
    int n_total = 0;
    int n_valid = 0;
    int m_nvalid = 0;

    // Reference model state: selected row, candidate key, held key.
    int         m_pc, m_row, m_cand, m_col, m_streak, m_rel;
    logic       m_held, m_valid;
    logic [3:0] m_code, m_h0, m_h1;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
        .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
        .key_valid(key_valid), .key_code(key_code), .key_pressed(key_pressed)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its column to the selected row.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
    end

    function automatic logic [3:0] pad(input int r, input logic [15:0] k);
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = ~k[r*4+c];
        return v;
    endfunction

    function automatic logic [3:0] exp_row_n();
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << m_row);
    endfunction

    task automatic on_tick(input logic [3:0] cs);
        logic low;
        low = ~cs[m_col];
        if (m_held) begin
            if (!low) begin
                m_rel++;
                if (m_rel == DT) begin
                    m_held = 1'b0;
                    m_row = (m_row + 1) % 4;
                end
            end else m_rel = 0;
        end else if (m_cand >= 0) begin
            if (low) begin
                m_streak++;
                if (m_streak == DT) begin
                    m_code = 4'(m_cand);
                    m_valid = 1'b1;
                    m_held = 1'b1;
                    m_rel = 0;
                    m_cand = -1;
                end
            end else begin
                m_cand = -1;
                m_row = (m_row + 1) % 4;
            end
        end else if (cs != 4'b1111) begin
            m_col = 3;
            for (int c = 3; c >= 0; c--) if (!cs[c]) m_col = c;
            m_cand = m_row * 4 + m_col;
            m_streak = 0;
        end else begin
            m_row = (m_row + 1) % 4;
        end
    endtask

    task automatic model_edge(input logic [3:0] smp);
        logic [3:0] cs;
        m_valid = 1'b0;
        if (!rst_n) begin
            m_pc = 0; m_row = 0; m_cand = -1; m_col = 0; m_streak = 0; m_rel = 0;
            m_held = 1'b0; m_code = 4'd0; m_h0 = 4'hF; m_h1 = 4'hF;
        end else begin
            cs = m_h1;
            m_h1 = m_h0;
            m_h0 = smp;
            if (m_pc == SD - 1) on_tick(cs);
            m_pc = (m_pc + 1) % SD;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] smp;
            smp = pad(m_row, keys);
            @(posedge clk);
            #1;
            model_edge(smp);
            if (key_valid === 1'b1) n_valid++;
            if (m_valid) m_nvalid++;
            n_total++;
            if ({row_n, key_valid, key_code, key_pressed} !==
                {exp_row_n(), m_valid, m_code, m_held})
                $display("FAIL model_cycle t=%0t: got row_n=%b valid=%b code=%0d pressed=%b, exp row_n=%b valid=%b code=%0d pressed=%b",
                         $time, row_n, key_valid, key_code, key_pressed,
                         exp_row_n(), m_valid, m_code, m_held);
            else n_pass++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic wait_pressed(input logic level, input int bound, input string name);
        int i;
        i = 0;
        while (key_pressed !== level && i < bound) begin
            step(1);
            i++;
        end
        if (key_pressed !== level) begin
            n_total++;
            $display("FAIL %s_timeout: key_pressed=%b after %0d cycles, exp %b", name, key_pressed, bound, level);
        end
    endtask

    task automatic test_reset();
        keys = 16'h0000;
        rst_n = 1'b0;
        step(2);
        n_total++;
        if ({row_n, key_valid, key_code, key_pressed} !== {4'b1110, 1'b0, 4'd0, 1'b0})
            $display("FAIL reset_values: got row_n=%b valid=%b code=%0d pressed=%b, exp 1110 0 0 0",
                     row_n, key_valid, key_code, key_pressed);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        logic [3:0] one, exp;
        int v0;
        one = 4'b0001;
        keys = 16'h0000;
        do_reset();
        v0 = n_valid;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            exp = ~(one << ((k / 4) % 4));
            n_total++;
            if (row_n !== exp || key_valid !== 1'b0)
                $display("FAIL idle_row k=%0d: got row_n=%b valid=%b, exp row_n=%b valid=0", k, row_n, key_valid, exp);
            else n_pass++;
        end
        n_total++;
        if (n_valid != v0) $display("FAIL idle_no_valid: got %0d pulses, exp 0", n_valid - v0);
        else n_pass++;
    endtask

    task automatic test_clean_press();
        int v0;
        do_reset();
        v0 = n_valid;
        keys = 16'h0000;
        keys[9] = 1'b1;
        wait_pressed(1'b1, 100, "clean_press");
        step(30);
        n_total++;
        if (n_valid - v0 != 1) $display("FAIL clean_pulse_count: got %0d, exp 1", n_valid - v0);
        else n_pass++;
        n_total++;
        if ({key_code, key_pressed, row_n} !== {4'd9, 1'b1, 4'b1011})
            $display("FAIL clean_hold: got code=%0d pressed=%b row_n=%b, exp 9 1 1011", key_code, key_pressed, row_n);
        else n_pass++;
        keys = 16'h0000;
        step(30);
    endtask

    task automatic test_bounce();
        int v0, i;
        do_reset();
        v0 = n_valid;
        keys = 16'h0000;
        keys[9] = 1'b1;
        i = 0;
        while (m_cand < 0 && i < 100) begin
            step(1);
            i++;
        end
        n_total++;
        if (m_cand != 9) $display("FAIL bounce_detect: got candidate %0d, exp 9", m_cand);
        else n_pass++;
        keys = 16'h0000;
        step(SD);
        n_total++;
        if (row_n !== 4'b0111 || n_valid != v0)
            $display("FAIL bounce_reject: got row_n=%b pulses=%0d, exp row_n=0111 pulses=0", row_n, n_valid - v0);
        else n_pass++;
    endtask

    task automatic test_release_priority();
        do_reset();
        keys = 16'h0000;
        keys[4] = 1'b1;
        keys[7] = 1'b1;
        wait_pressed(1'b1, 100, "prio_press");
        n_total++;
        if (key_code !== 4'd4) $display("FAIL prio_code: got %0d, exp 4", key_code);
        else n_pass++;
        step(10);
        keys = 16'h0000;
        wait_pressed(1'b0, 40, "prio_release");
        n_total++;
        if (row_n !== 4'b1011) $display("FAIL release_resume_row: got %b, exp 1011", row_n);
        else n_pass++;
        step(8);
    endtask

    task automatic test_no_rollover();
        int v0, i;
        do_reset();
        keys = 16'h0000;
        keys[4] = 1'b1;
        wait_pressed(1'b1, 100, "roll_press");
        v0 = n_valid;
        keys[13] = 1'b1;
        step(60);
        n_total++;
        if (n_valid != v0 || key_code !== 4'd4)
            $display("FAIL no_rollover: got pulses=%0d code=%0d, exp pulses=0 code=4", n_valid - v0, key_code);
        else n_pass++;
        keys[4] = 1'b0;
        wait_pressed(1'b0, 40, "roll_release");
        n_total++;
        if (row_n !== 4'b1011) $display("FAIL roll_resume_row: got %b, exp 1011", row_n);
        else n_pass++;
        i = 0;
        while (key_valid !== 1'b1 && i < 100) begin
            step(1);
            i++;
        end
        n_total++;
        if (key_valid !== 1'b1 || key_code !== 4'd13)
            $display("FAIL roll_second_key: got valid=%b code=%0d, exp valid=1 code=13", key_valid, key_code);
        else n_pass++;
        keys = 16'h0000;
        step(30);
    endtask

    task automatic test_reset_hold();
        do_reset();
        keys = 16'h0000;
        keys[6] = 1'b1;
        wait_pressed(1'b1, 100, "rst_hold_press");
        step(5);
        rst_n = 1'b0;
        step(1);
        n_total++;
        if ({row_n, key_pressed, key_code, key_valid} !== {4'b1110, 1'b0, 4'd0, 1'b0})
            $display("FAIL reset_mid_hold: got row_n=%b pressed=%b code=%0d valid=%b, exp 1110 0 0 0",
                     row_n, key_pressed, key_code, key_valid);
        else n_pass++;
        rst_n = 1'b1;
        keys = 16'h0000;
        step(10);
    endtask

    task automatic test_random();
        int v0, mv0, hold;
        logic [15:0] base;
        do_reset();
        v0 = n_valid;
        mv0 = m_nvalid;
        for (int it = 0; it < 16; it++) begin
            base = 16'h0000;
            base[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 1) == 1) base[$urandom_range(0, 15)] = 1'b1;
            keys = base;
            hold = $urandom_range(20, 120);
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(0, 15) == 0) keys = keys ^ base;
                step(1);
            end
            keys = 16'h0000;
            step($urandom_range(20, 60));
            if ($urandom_range(0, 7) == 0) do_reset();
        end
        n_total++;
        if (n_valid - v0 != m_nvalid - mv0)
            $display("FAIL random_pulse_count: got %0d, exp %0d", n_valid - v0, m_nvalid - mv0);
        else n_pass++;
    endtask

    initial begin
        m_pc = 0; m_row = 0; m_cand = -1; m_col = 0; m_streak = 0; m_rel = 0;
        m_held = 1'b0; m_valid = 1'b0; m_code = 4'd0; m_h0 = 4'hF; m_h1 = 4'hF;
        test_reset();
        test_idle();
        test_clean_press();
        test_bounce();
        test_release_priority();
        test_no_rollover();
        test_reset_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
